// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor FSM states; encodings are visible on the state port.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUNNING   = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  // Bits needed for a counter that must represent 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) <= 64'(max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchronizer for a single asynchronous status flag.
module pll_sup_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the async input; both flops clear to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: PLL reset sequencing, lock qualification,
// timeout/retry handling and downstream reset release.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 restart,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 out_reset_n,
  output logic                 lock_ok,
  output logic                 fail,
  output logic [2:0]           state,
  output logic [RETRY_W-1:0]   retry_count,
  output logic [LOSS_W-1:0]    loss_count
);

  localparam int unsigned RST_W  = cnt_width(RST_CYCLES);
  localparam int unsigned STAB_W = cnt_width(STABLE_CYCLES);
  localparam int unsigned TMO_W  = cnt_width(TIMEOUT_CYCLES);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

  pll_state_e          state_q;
  logic                pll_rst_q;
  logic                out_rst_n_q;
  logic                lock_ok_q;
  logic                fail_q;
  logic [RST_W-1:0]    rst_cnt_q;
  logic [STAB_W-1:0]   stab_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [RETRY_W-1:0]  retry_q;
  logic [LOSS_W-1:0]   loss_q;
  logic                locked_s;

  pll_sup_sync u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Supervisor FSM with its timers, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET_PLL;
      pll_rst_q   <= 1'b1;
      out_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
      rst_cnt_q   <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else if (restart) begin
      // A loss coinciding with restart is still recorded.
      if (state_q == ST_RUNNING && !locked_s && loss_q != LOSS_SAT) begin
        loss_q <= loss_q + LOSS_W'(1);
      end
      state_q     <= ST_RESET_PLL;
      pll_rst_q   <= 1'b1;
      out_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
      rst_cnt_q   <= '0;
      retry_q     <= '0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            pll_rst_q <= 1'b0;
            rst_cnt_q <= '0;
            tmo_q     <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end
        ST_WAIT_LOCK, ST_STABILIZE: begin
          // Timeout spans both states and ignores lock chatter.
          if (tmo_q == TMO_LAST) begin
            pll_rst_q <= 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q   <= ST_RESET_PLL;
              retry_q   <= retry_q + RETRY_W'(1);
              rst_cnt_q <= '0;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (state_q == ST_WAIT_LOCK) begin
              if (locked_s) begin
                state_q <= ST_STABILIZE;
                stab_q  <= '0;
              end
            end else if (!locked_s) begin
              state_q <= ST_WAIT_LOCK;
            end else if (stab_q == STAB_LAST) begin
              state_q     <= ST_RUNNING;
              out_rst_n_q <= 1'b1;
              lock_ok_q   <= 1'b1;
            end else begin
              stab_q <= stab_q + STAB_W'(1);
            end
          end
        end
        ST_RUNNING: begin
          if (!locked_s) begin
            if (loss_q != LOSS_SAT) loss_q <= loss_q + LOSS_W'(1);
            state_q     <= ST_RESET_PLL;
            pll_rst_q   <= 1'b1;
            out_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            rst_cnt_q   <= '0;
            retry_q     <= '0;
          end
        end
        ST_FAIL: begin
          pll_rst_q   <= 1'b1;
          out_rst_n_q <= 1'b0;
          fail_q      <= 1'b1;
        end
        default: begin
          state_q     <= ST_RESET_PLL;
          pll_rst_q   <= 1'b1;
          out_rst_n_q <= 1'b0;
          lock_ok_q   <= 1'b0;
          fail_q      <= 1'b0;
          rst_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pll_rst     = pll_rst_q;
  assign out_reset_n = out_rst_n_q;
  assign lock_ok     = lock_ok_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       out_reset_n;
  logic       lock_ok;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int total = 0;
  int bad = 0;

  pll_lock_supervisor #(
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .MAX_RETRIES    (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (restart),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .out_reset_n (out_reset_n),
    .lock_ok     (lock_ok),
    .fail        (fail),
    .state       (state),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    restart = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    total++; if (out_reset_n !== 1'b0) begin bad++; $display("FAIL reset_out_reset_n got=%b want=0", out_reset_n); end
    total++; if (lock_ok !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", lock_ok, fail); end
    total++; if (retry_count !== 4'd0 || loss_count !== 8'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", retry_count, loss_count); end
  endtask

  task automatic test_bringup();
    int n;
    reset_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL bringup_rst_width got=%0d want=4", n); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL bringup_wait_state got=%0d want=1", state); end
    repeat (5) tick();
    pll_locked = 1'b1;
    n = 0;
    while (out_reset_n !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (n != 11) begin bad++; $display("FAIL bringup_release_latency got=%0d want=11", n); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL bringup_state got=%0d want=3", state); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL bringup_retry got=%0d want=0", retry_count); end
    total++; if (lock_ok !== 1'b1 || pll_rst !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL bringup_outputs got lock_ok=%b pll_rst=%b fail=%b want 1 0 0", lock_ok, pll_rst, fail); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (out_reset_n === 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != 3) begin bad++; $display("FAIL loss_latency got=%0d want=3", n); end
    total++; if (state !== 3'd0 || pll_rst !== 1'b1 || lock_ok !== 1'b0) begin bad++; $display("FAIL loss_outputs got state=%0d pll_rst=%b lock_ok=%b want 0 1 0", state, pll_rst, lock_ok); end
    total++; if (loss_count !== 8'd1) begin bad++; $display("FAIL loss_count got=%0d want=1", loss_count); end
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd3 && n < 100) begin tick(); n++; end
    total++; if (n != 13) begin bad++; $display("FAIL loss_rebringup got=%0d want=13", n); end
    total++; if (out_reset_n !== 1'b1 || loss_count !== 8'd1 || retry_count !== 4'd0) begin bad++; $display("FAIL loss_rerun got out_reset_n=%b loss=%0d retry=%0d want 1 1 0", out_reset_n, loss_count, retry_count); end
  endtask

  task automatic test_restart_loss();
    pll_locked = 1'b0;
    tick();
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rl_pre_state got=%0d want=3", state); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rl_state got=%0d want=0", state); end
    total++; if (loss_count !== 8'd2) begin bad++; $display("FAIL rl_loss got=%0d want=2", loss_count); end
    total++; if (pll_rst !== 1'b1 || out_reset_n !== 1'b0 || retry_count !== 4'd0) begin bad++; $display("FAIL rl_outputs got pll_rst=%b out_reset_n=%b retry=%0d want 1 0 0", pll_rst, out_reset_n, retry_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 50) begin tick(); n++; end
    total++; if (n != 5) begin bad++; $display("FAIL mid_reach_stabilize got=%0d want=5", n); end
    reset_n = 1'b0;
    #1;
    total++; if (state !== 3'd0 || pll_rst !== 1'b1) begin bad++; $display("FAIL mid_async got state=%0d pll_rst=%b want 0 1", state, pll_rst); end
    total++; if (out_reset_n !== 1'b0 || lock_ok !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL mid_flags got %b%b%b want 000", out_reset_n, lock_ok, fail); end
    total++; if (loss_count !== 8'd0 || retry_count !== 4'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d want=0/0", loss_count, retry_count); end
  endtask

  task automatic test_no_lock();
    int n;
    pll_locked = 1'b0;
    do_reset();
    for (int a = 0; a < 3; a++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
      total++; if (n != 4) begin bad++; $display("FAIL nolock_rst_width att=%0d got=%0d want=4", a, n); end
      n = 0;
      while (pll_rst === 1'b0 && n < 100) begin tick(); n++; end
      total++; if (n != 32) begin bad++; $display("FAIL nolock_timeout att=%0d got=%0d want=32", a, n); end
      if (a < 2) begin
        total++; if (retry_count !== 4'(a + 1) || state !== 3'd0) begin bad++; $display("FAIL nolock_retry att=%0d got retry=%0d state=%0d want %0d 0", a, retry_count, state, a + 1); end
      end else begin
        total++; if (state !== 3'd4 || fail !== 1'b1 || retry_count !== 4'd2) begin bad++; $display("FAIL nolock_fail got state=%0d fail=%b retry=%0d want 4 1 2", state, fail, retry_count); end
      end
    end
    repeat (10) tick();
    total++; if (state !== 3'd4 || pll_rst !== 1'b1 || out_reset_n !== 1'b0 || fail !== 1'b1) begin bad++; $display("FAIL nolock_park got state=%0d pll_rst=%b out=%b fail=%b want 4 1 0 1", state, pll_rst, out_reset_n, fail); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (state !== 3'd0 || retry_count !== 4'd0 || fail !== 1'b0 || pll_rst !== 1'b1) begin bad++; $display("FAIL nolock_restart got state=%0d retry=%0d fail=%b pll_rst=%b want 0 0 0 1", state, retry_count, fail, pll_rst); end
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL nolock_restart_width got=%0d want=4", n); end
  endtask

  task automatic test_chatter();
    int n;
    bit hit;
    pll_locked = 1'b0;
    do_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL chatter_rst_width got=%0d want=4", n); end
    for (int a = 0; a < 2; a++) begin
      pll_locked = 1'b1;
      n = 0;
      hit = 1'b0;
      while (pll_rst === 1'b0 && n < 100) begin
        tick();
        n++;
        if (state === 3'd3 || out_reset_n !== 1'b0) hit = 1'b1;
        if (n % 5 == 0) pll_locked = ~pll_locked;
      end
      total++; if (n != 32) begin bad++; $display("FAIL chatter_timeout att=%0d got=%0d want=32", a, n); end
      total++; if (hit != 1'b0) begin bad++; $display("FAIL chatter_running att=%0d got=%b want=0", a, hit); end
      total++; if (retry_count !== 4'(a + 1)) begin bad++; $display("FAIL chatter_retry att=%0d got=%0d want=%0d", a, retry_count, a + 1); end
      pll_locked = 1'b0;
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    end
  endtask

  task automatic test_loss_saturation();
    int n;
    bit ok;
    pll_locked = 1'b1;
    do_reset();
    n = 0;
    while (state !== 3'd3 && n < 100) begin tick(); n++; end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL sat_initial_run got=%0d want=3", state); end
    ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      n = 0;
      while (state !== 3'd0 && n < 20) begin tick(); n++; end
      if (n >= 20) ok = 1'b0;
      pll_locked = 1'b1;
      n = 0;
      while (state !== 3'd3 && n < 50) begin tick(); n++; end
      if (n >= 50) ok = 1'b0;
      if (i == 254) begin
        total++; if (loss_count !== 8'd255) begin bad++; $display("FAIL sat_at_255 got=%0d want=255", loss_count); end
      end
    end
    total++; if (ok != 1'b1) begin bad++; $display("FAIL sat_cycles got=%b want=1", ok); end
    total++; if (loss_count !== 8'd255) begin bad++; $display("FAIL sat_at_256 got=%0d want=255", loss_count); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_restart_loss();
    test_reset_mid();
    test_no_lock();
    test_chatter();
    test_loss_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
